// File: rtl/uart_tx_engine.sv
// 8N1/8N2 asynchronous serial transmitter with a one-entry holding register
// so the next byte can be queued while the current frame is on the wire.
module uart_tx_engine #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_ready,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_overrun,
    output logic       txd
);

    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_e;

    state_e            state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic [7:0]        hold_q, hold_d;
    logic              hold_vld_q, hold_vld_d;
    logic              txd_q, txd_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              ready_q, ready_d;

    logic              baud_end;
    logic              frame_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            txd_q      <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            ready_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            txd_q      <= txd_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            ready_q    <= ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        done_d     = 1'b0;
        ovr_d      = 1'b0;

        baud_end  = (baud_q == BAUD_LAST);
        frame_end = (state_q == STOP) && baud_end && (bit_q == STOP_LAST);

        case (state_q)
            IDLE: begin
                if (tx_start) begin
                    shift_d = tx_data;
                    state_d = START;
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            START: begin
                if (baud_end) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        bit_d   = '0;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    bit_d  = bit_q + 1'b1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Last stop cycle: chain the next frame straight into START; a strobe
        // here is never an overrun because the hold slot frees up this edge.
        if (frame_end) begin
            done_d = 1'b1;
            bit_d  = '0;
            baud_d = '0;
            if (hold_vld_q) begin
                shift_d = hold_q;
                state_d = START;
                if (tx_start) begin
                    hold_d = tx_data;
                end else begin
                    hold_vld_d = 1'b0;
                end
            end else if (tx_start) begin
                shift_d = tx_data;
                state_d = START;
            end else begin
                state_d = IDLE;
            end
        end else if (state_q != IDLE && tx_start) begin
            if (!hold_vld_q) begin
                hold_d     = tx_data;
                hold_vld_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_comb begin
        txd_d = 1'b1;
        case (state_q)
            IDLE:    txd_d = 1'b1;
            START:   txd_d = 1'b0;
            DATA:    txd_d = shift_q[bit_q];
            STOP:    txd_d = 1'b1;
            default: txd_d = 1'b1;
        endcase
        busy_d  = (state_q != IDLE);
        ready_d = !hold_vld_q;
    end

    assign txd        = txd_q;
    assign tx_busy    = busy_q;
    assign tx_done    = done_q;
    assign tx_overrun = ovr_q;
    assign tx_ready   = ready_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed bench for uart_tx_engine: one instance at 4 clk/bit 1 stop, one at
// 2 clk/bit 2 stop; the line is recorded per cycle and compared to a frame model.
module tb_uart_tx_engine;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       drv_start = 1'b0;
    logic [7:0] drv_data = 8'h00;
    logic       use2 = 1'b0;

    logic txd_a, busy_a, done_a, ovr_a, ready_a;
    logic txd_b, busy_b, done_b, ovr_b, ready_b;
    logic start_a, start_b;
    logic o_txd, o_busy, o_done, o_ovr, o_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [255:0] wave, rdy, bsy;
    int done_cnt, done_first, done_last, ovr_cnt, ovr_at, busy_fall;

    always #5 clk = ~clk;

    assign start_a = use2 ? 1'b0 : drv_start;
    assign start_b = use2 ? drv_start : 1'b0;
    assign o_txd   = use2 ? txd_b   : txd_a;
    assign o_busy  = use2 ? busy_b  : busy_a;
    assign o_done  = use2 ? done_b  : done_a;
    assign o_ovr   = use2 ? ovr_b   : ovr_a;
    assign o_ready = use2 ? ready_b : ready_a;

    uart_tx_engine #(.CLKS_PER_BIT(4), .STOP_BITS(1)) u_dut_a (
        .clk(clk), .reset(reset), .tx_data(drv_data), .tx_start(start_a),
        .tx_ready(ready_a), .tx_busy(busy_a), .tx_done(done_a),
        .tx_overrun(ovr_a), .txd(txd_a)
    );

    uart_tx_engine #(.CLKS_PER_BIT(2), .STOP_BITS(2)) u_dut_b (
        .clk(clk), .reset(reset), .tx_data(drv_data), .tx_start(start_b),
        .tx_ready(ready_b), .tx_busy(busy_b), .tx_done(done_b),
        .tx_overrun(ovr_b), .txd(txd_b)
    );

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected line for back-to-back frames, the first starting at edge 0.
    function automatic logic [255:0] exp_wave(input int cpb, input int nstop, input int nfr,
                                              input logic [7:0] f0, input logic [7:0] f1,
                                              input logic [7:0] f2, input int ncyc);
        logic [255:0] e;
        logic [7:0]   b;
        int           len, sf, idx;
        e   = '0;
        len = (9 + nstop) * cpb;
        for (int k = 0; k <= ncyc; k++) begin
            e[k] = 1'b1;
            for (int f = 0; f < nfr; f++) begin
                b  = (f == 0) ? f0 : (f == 1) ? f1 : f2;
                sf = f * len;
                if (k > sf && k <= sf + len) begin
                    idx = (k - sf - 1) / cpb;
                    if (idx == 0)      e[k] = 1'b0;
                    else if (idx <= 8) e[k] = b[idx-1];
                end
            end
        end
        return e;
    endfunction

    // First byte is sampled at edge 0; extra strobes are sampled at edges t1/t2 (0 = none).
    task automatic scenario(input bit s_use2, input int ncyc, input logic [7:0] b0,
                            input int t1, input logic [7:0] b1,
                            input int t2, input logic [7:0] b2);
        use2 = s_use2;
        wave = '0; rdy = '0; bsy = '0;
        done_cnt = 0; done_first = -1; done_last = -1;
        ovr_cnt = 0; ovr_at = -1; busy_fall = -1;
        drv_start = 1'b1;
        drv_data  = b0;
        for (int k = 0; k <= ncyc; k++) begin
            @(posedge clk); #1;
            wave[k] = o_txd;
            rdy[k]  = o_ready;
            bsy[k]  = o_busy;
            if (o_done) begin
                if (done_cnt == 0) done_first = k;
                done_last = k;
                done_cnt++;
            end
            if (o_ovr) begin
                ovr_cnt++;
                ovr_at = k;
            end
            if (k > 0 && !o_busy && busy_fall < 0) busy_fall = k;
            drv_start = 1'b0;
            drv_data  = 8'($urandom);
            if (t1 > 0 && k == t1 - 1) begin drv_start = 1'b1; drv_data = b1; end
            if (t2 > 0 && k == t2 - 1) begin drv_start = 1'b1; drv_data = b2; end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [255:0] idle;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        check_eq("rst_txd",   256'(txd_a),   256'(1'b1));
        check_eq("rst_busy",  256'(busy_a),  256'(1'b0));
        check_eq("rst_ready", 256'(ready_a), 256'(1'b1));
        check_eq("rst_done",  256'(done_a),  256'(1'b0));
        check_eq("rst_ovr",   256'(ovr_a),   256'(1'b0));
        check_eq("rst_txd_b", 256'(txd_b),   256'(1'b1));
        @(posedge clk); #1;

        // Single byte 0xCC
        scenario(1'b0, 45, 8'hCC, 0, 8'h00, 0, 8'h00);
        check_eq("cc_wave",  wave, exp_wave(4, 1, 1, 8'hCC, 8'h00, 8'h00, 45));
        check_eq("cc_busy1", 256'(bsy[1]), 256'(1'b1));
        check_eq("cc_dcnt",  256'(done_cnt), 256'(1));
        check_eq("cc_done",  256'(done_first), 256'(40));
        check_eq("cc_bfall", 256'(busy_fall), 256'(41));
        check_eq("cc_ovr",   256'(ovr_cnt), 256'(0));

        // Back-to-back 0x55 then 0xA3 queued at edge 10
        scenario(1'b0, 85, 8'h55, 10, 8'hA3, 0, 8'h00);
        check_eq("b2b_wave",  wave, exp_wave(4, 1, 2, 8'h55, 8'hA3, 8'h00, 85));
        check_eq("b2b_rdy10", 256'(rdy[10]), 256'(1'b1));
        check_eq("b2b_rdy11", 256'(rdy[11]), 256'(1'b0));
        check_eq("b2b_rdy41", 256'(rdy[41]), 256'(1'b1));
        check_eq("b2b_dcnt",  256'(done_cnt), 256'(2));
        check_eq("b2b_d1",    256'(done_first), 256'(40));
        check_eq("b2b_d2",    256'(done_last), 256'(80));
        check_eq("b2b_bfall", 256'(busy_fall), 256'(81));

        // Overrun: 0xFF while 0xA3 is held
        scenario(1'b0, 85, 8'h55, 10, 8'hA3, 20, 8'hFF);
        check_eq("ovr_wave",  wave, exp_wave(4, 1, 2, 8'h55, 8'hA3, 8'h00, 85));
        check_eq("ovr_cnt",   256'(ovr_cnt), 256'(1));
        check_eq("ovr_at",    256'(ovr_at), 256'(20));
        check_eq("ovr_rdy20", 256'(rdy[20]), 256'(1'b0));
        check_eq("ovr_dcnt",  256'(done_cnt), 256'(2));

        // Strobe in last stop cycle with hold empty
        scenario(1'b0, 85, 8'h3C, 40, 8'hC5, 0, 8'h00);
        check_eq("lse_wave",  wave, exp_wave(4, 1, 2, 8'h3C, 8'hC5, 8'h00, 85));
        check_eq("lse_ovr",   256'(ovr_cnt), 256'(0));
        check_eq("lse_rdy41", 256'(rdy[41]), 256'(1'b1));
        check_eq("lse_d2",    256'(done_last), 256'(80));
        check_eq("lse_bfall", 256'(busy_fall), 256'(81));

        // Strobe in last stop cycle with hold full
        scenario(1'b0, 125, 8'h55, 10, 8'hA3, 40, 8'h96);
        check_eq("lsf_wave",  wave, exp_wave(4, 1, 3, 8'h55, 8'hA3, 8'h96, 125));
        check_eq("lsf_ovr",   256'(ovr_cnt), 256'(0));
        check_eq("lsf_rdy41", 256'(rdy[41]), 256'(1'b0));
        check_eq("lsf_rdy81", 256'(rdy[81]), 256'(1'b1));
        check_eq("lsf_dcnt",  256'(done_cnt), 256'(3));
        check_eq("lsf_bfall", 256'(busy_fall), 256'(121));

        // Reset during data bit 3 of 0x0F
        use2 = 1'b0;
        drv_start = 1'b1;
        drv_data  = 8'h0F;
        @(posedge clk); #1;
        drv_start = 1'b0;
        repeat (18) @(posedge clk);
        #1;
        check_eq("mrst_busy_pre", 256'(busy_a), 256'(1'b1));
        #2 reset = 1'b1;
        #1;
        check_eq("mrst_txd",   256'(txd_a),   256'(1'b1));
        check_eq("mrst_busy",  256'(busy_a),  256'(1'b0));
        check_eq("mrst_ready", 256'(ready_a), 256'(1'b1));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        idle = '0;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            idle[k] = txd_a & !busy_a & !done_a;
        end
        check_eq("mrst_idle", idle, 256'({30{1'b1}}));
        scenario(1'b0, 45, 8'h81, 0, 8'h00, 0, 8'h00);
        check_eq("mrst_wave", wave, exp_wave(4, 1, 1, 8'h81, 8'h00, 8'h00, 45));
        check_eq("mrst_done", 256'(done_first), 256'(40));

        // Two stop bits, 2 clk/bit, byte 0x00
        scenario(1'b1, 25, 8'h00, 0, 8'h00, 0, 8'h00);
        check_eq("s2_wave",  wave, exp_wave(2, 2, 1, 8'h00, 8'h00, 8'h00, 25));
        check_eq("s2_dcnt",  256'(done_cnt), 256'(1));
        check_eq("s2_done",  256'(done_first), 256'(22));
        check_eq("s2_bfall", 256'(busy_fall), 256'(23));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
